mem_ctrl: RTL and testbench

Sequences the single byte-wide RAM port and shares it between the instruction fetcher and the load/store buffer. Each requester asks for one word or sub-word access. The block arbitrates, then steps the RAM one byte per cycle. It assembles little-endian read data and returns it with a one-cycle done pulse. It handles pipeline flush, rdy pauses and I/O write back-pressure.

---
 rtl/mem_ctrl_pkg.sv | 36 +++
 rtl/mem_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM port sequencer: state and owner
// encodings, access length codes and the I/O address selector.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  // The reset value of the last-grant bit is OWN_IF, so a tie after reset goes to the LSB.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_LSB = 1'b1
  } mc_owner_e;

  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_4B = 2'd3;

  localparam logic [2:0] IF_BYTES       = 3'd4;
  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  function automatic logic [2:0] lenToBytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_1B:  n = 3'd1;
      LEN_2B:  n = 3'd2;
      LEN_4B:  n = 3'd4;
      default: n = {1'b0, len} + 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the RAM port between fetch and load/store and steps it one byte
// per cycle, assembling little-endian read data behind a one-cycle done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong_stall,
  input  logic        IF_req,
  input  logic [31:0] IF_addr,
  output logic        IF_flag,
  output logic [31:0] IF_inst,
  input  logic        LSB_req,
  input  logic        LSB_wr,
  input  logic [1:0]  LSB_len,
  input  logic [31:0] LSB_addr,
  input  logic [31:0] LSB_wdata,
  output logic        LSB_flag,
  output logic [31:0] LSB_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mc_state_e   state_q, state_d;
  mc_owner_e   owner_q, owner_d;
  mc_owner_e   lastGrant_q, lastGrant_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  nBytes_q, nBytes_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  issueCnt_q, issueCnt_d;
  logic [2:0]  capCnt_q, capCnt_d;
  logic        pending_q, pending_d;

  logic        ioBlocked;
  logic        grantLsb;
  logic        issueNow;

  assign ioBlocked = (base_q[17:16] == IO_SEL) && io_buffer_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MC_IDLE;
      owner_q     <= OWN_IF;
      lastGrant_q <= OWN_IF;
      base_q      <= '0;
      nBytes_q    <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      issueCnt_q  <= '0;
      capCnt_q    <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastGrant_q <= lastGrant_d;
      base_q      <= base_d;
      nBytes_q    <= nBytes_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      issueCnt_q  <= issueCnt_d;
      capCnt_q    <= capCnt_d;
      pending_q   <= pending_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastGrant_d = lastGrant_q;
    base_d      = base_q;
    nBytes_d    = nBytes_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    issueCnt_d  = issueCnt_q;
    capCnt_d    = capCnt_q;
    pending_d   = pending_q;
    grantLsb    = 1'b0;
    issueNow    = 1'b0;

    case (state_q)
      MC_IDLE: begin
        if (rdy && !jump_wrong_stall && (IF_req || LSB_req)) begin
          grantLsb   = LSB_req && (!IF_req || (lastGrant_q == OWN_IF));
          issueCnt_d = '0;
          capCnt_d   = '0;
          pending_d  = 1'b0;
          data_d     = '0;
          if (grantLsb) begin
            owner_d     = OWN_LSB;
            lastGrant_d = OWN_LSB;
            base_d      = LSB_addr;
            nBytes_d    = lenToBytes(LSB_len);
            wdata_d     = LSB_wdata;
            state_d     = LSB_wr ? MC_WRITE : MC_READ;
          end else begin
            owner_d     = OWN_IF;
            lastGrant_d = OWN_IF;
            base_d      = IF_addr;
            nBytes_d    = IF_BYTES;
            state_d     = MC_READ;
          end
        end
      end

      // A pause rewinds issue to the capture point: data for the byte issued
      // just before the pause arrives while capture is frozen and is lost.
      MC_READ: begin
        if (jump_wrong_stall) begin
          state_d   = MC_IDLE;
          pending_d = 1'b0;
        end else if (!rdy) begin
          issueCnt_d = capCnt_q;
          pending_d  = 1'b0;
        end else begin
          issueNow  = issueCnt_q < nBytes_q;
          pending_d = issueNow;
          if (issueNow) begin
            issueCnt_d = issueCnt_q + 3'd1;
          end
          if (pending_q) begin
            data_d[{capCnt_q[1:0], 3'b000} +: 8] = mem_din;
            capCnt_d = capCnt_q + 3'd1;
            if ((capCnt_q + 3'd1) == nBytes_q) begin
              state_d = MC_DONE;
            end
          end
        end
      end

      MC_WRITE: begin
        if (rdy && !ioBlocked) begin
          issueCnt_d = issueCnt_q + 3'd1;
          if ((issueCnt_q + 3'd1) == nBytes_q) begin
            state_d = MC_DONE;
          end
        end
      end

      MC_DONE: begin
        if (rdy) begin
          state_d = MC_IDLE;
        end
      end

      default: state_d = MC_IDLE;
    endcase
  end

  always_comb begin
    IF_flag   = 1'b0;
    IF_inst   = '0;
    LSB_flag  = 1'b0;
    LSB_rdata = '0;
    mem_a     = '0;
    mem_wr    = 1'b0;
    mem_dout  = '0;

    case (state_q)
      MC_READ: begin
        if (rdy && (issueCnt_q < nBytes_q)) begin
          mem_a = base_q + {29'd0, issueCnt_q};
        end
      end

      MC_WRITE: begin
        if (rdy) begin
          mem_a    = base_q + {29'd0, issueCnt_q};
          mem_dout = wdata_q[{issueCnt_q[1:0], 3'b000} +: 8];
          mem_wr   = !ioBlocked;
        end
      end

      MC_DONE: begin
        if (rdy) begin
          if (owner_q == OWN_IF) begin
            IF_flag = 1'b1;
            IF_inst = data_q;
          end else begin
            LSB_flag  = 1'b1;
            LSB_rdata = data_q;
          end
        end
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// transactions checked against a byte-array memory model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy, jump_wrong_stall;
  logic        IF_req, IF_flag;
  logic [31:0] IF_addr, IF_inst;
  logic        LSB_req, LSB_wr, LSB_flag;
  logic [1:0]  LSB_len;
  logic [31:0] LSB_addr, LSB_wdata, LSB_rdata;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  int vectors = 0;
  int miscompares = 0;

  byte unsigned envMem[int unsigned];
  byte unsigned refMem[int unsigned];

  int          ifFlagCyc, lsbFlagCyc, ifFlagCount, lsbFlagCount;
  logic [31:0] ifData, lsbData;
  logic [31:0] aLog[64];
  logic        wLog[64];
  logic [7:0]  dLog[64];
  logic [31:0] wrAddrQ[$];
  logic [7:0]  wrDataQ[$];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong_stall(jump_wrong_stall),
    .IF_req(IF_req), .IF_addr(IF_addr), .IF_flag(IF_flag), .IF_inst(IF_inst),
    .LSB_req(LSB_req), .LSB_wr(LSB_wr), .LSB_len(LSB_len), .LSB_addr(LSB_addr),
    .LSB_wdata(LSB_wdata), .LSB_flag(LSB_flag), .LSB_rdata(LSB_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  function automatic logic [7:0] initByte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] envRead(input logic [31:0] a);
    if (envMem.exists(a)) return envMem[a];
    return initByte(a);
  endfunction

  function automatic logic [7:0] refRead(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return initByte(a);
  endfunction

  // RAM returns the byte for this cycle's address on the next cycle.
  always @(posedge clk) begin
    mem_din <= envRead(mem_a);
    if (mem_wr) envMem[mem_a] = mem_dout;
  end

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = refRead(a + 32'(i));
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    envMem[a] = b;
    refMem[a] = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle 0 of each call is the cycle the requests first appear; requesters
  // drop req the cycle after their flag, and flushed loads/fetches withdraw.
  task automatic applyStimulus(input bit ifOn, input bit lsbOn, input bit wr,
                               input logic [1:0] len, input logic [31:0] ifA,
                               input logic [31:0] lsbA, input logic [31:0] wd,
                               input logic [63:0] rdyOff, input logic [63:0] flushM,
                               input logic [63:0] fullM, input int budget);
    bit ifAct, lsbAct;
    ifAct = ifOn;
    lsbAct = lsbOn;
    ifFlagCyc = -1; lsbFlagCyc = -1; ifFlagCount = 0; lsbFlagCount = 0;
    ifData = '0; lsbData = '0;
    wrAddrQ.delete(); wrDataQ.delete();
    IF_addr = ifA; LSB_addr = lsbA; LSB_wr = wr; LSB_len = len; LSB_wdata = wd;
    for (int c = 0; c < budget; c++) begin
      IF_req = ifAct; LSB_req = lsbAct;
      rdy = !rdyOff[c]; jump_wrong_stall = flushM[c]; io_buffer_full = fullM[c];
      @(negedge clk);
      aLog[c] = mem_a; wLog[c] = mem_wr; dLog[c] = mem_dout;
      if (mem_wr) begin
        wrAddrQ.push_back(mem_a);
        wrDataQ.push_back(mem_dout);
      end
      if (IF_flag) begin
        ifFlagCount++;
        if (ifFlagCyc < 0) begin ifFlagCyc = c; ifData = IF_inst; end
        ifAct = 1'b0;
      end
      if (LSB_flag) begin
        lsbFlagCount++;
        if (lsbFlagCyc < 0) begin lsbFlagCyc = c; lsbData = LSB_rdata; end
        lsbAct = 1'b0;
      end
      if (flushM[c]) begin
        ifAct = 1'b0;
        if (!wr) lsbAct = 1'b0;
      end
      @(posedge clk); #1;
    end
    IF_req = 1'b0; LSB_req = 1'b0; rdy = 1'b1; jump_wrong_stall = 1'b0; io_buffer_full = 1'b0;
  endtask

  task automatic modelStore(input logic [31:0] a, input int n, input logic [31:0] wd);
    for (int i = 0; i < n; i++) refMem[a + 32'(i)] = wd[8*i +: 8];
  endtask

  task automatic checkWrites(input string tag, input logic [31:0] a, input int n, input logic [31:0] wd);
    checkOutput({tag, "_wcount"}, wrAddrQ.size(), n);
    if (wrAddrQ.size() == n) begin
      for (int i = 0; i < n; i++) begin
        checkOutput({tag, "_waddr"}, wrAddrQ[i], a + 32'(i));
        checkOutput({tag, "_wdata"}, {24'd0, wrDataQ[i]}, {24'd0, wd[8*i +: 8]});
      end
    end
  endtask

  initial begin
    int nFlags;
    rst = 1'b1; rdy = 1'b1; jump_wrong_stall = 1'b0; io_buffer_full = 1'b0;
    IF_req = 1'b0; IF_addr = '0; LSB_req = 1'b0; LSB_wr = 1'b0; LSB_len = '0;
    LSB_addr = '0; LSB_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_if_flag", {31'd0, IF_flag}, 0);
    checkOutput("rst_lsb_flag", {31'd0, LSB_flag}, 0);
    checkOutput("rst_mem_wr", {31'd0, mem_wr}, 0);
    checkOutput("rst_mem_a", mem_a, 0);
    checkOutput("rst_mem_dout", {24'd0, mem_dout}, 0);
    checkOutput("rst_if_inst", IF_inst, 0);
    checkOutput("rst_lsb_rdata", LSB_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    preload(32'h1002, 8'h34); preload(32'h1003, 8'h12);

    // Plain 4-byte fetch: addresses in cycles 1-4, flag in cycle 6.
    applyStimulus(1, 0, 0, 2'd0, 32'h100, 0, 0, 0, 0, 0, 24);
    for (int i = 1; i <= 4; i++) checkOutput("t1_mem_a", aLog[i], 32'h100 + 32'(i - 1));
    checkOutput("t1_mem_wr", {31'd0, wLog[1]}, 0);
    checkOutput("t1_flag_cyc", ifFlagCyc, 6);
    checkOutput("t1_inst", ifData, 32'h0000_0513);
    checkOutput("t1_flag_count", ifFlagCount, 1);
    checkOutput("t1_done_mem_a", aLog[6], 0);

    applyStimulus(0, 1, 0, 2'd1, 0, 32'h1002, 0, 0, 0, 0, 24);
    checkOutput("t2_flag_cyc", lsbFlagCyc, 4);
    checkOutput("t2_rdata", lsbData, 32'h0000_1234);

    // I/O store held off by back-pressure in cycles 1-3.
    applyStimulus(0, 1, 1, 2'd0, 0, 32'h0003_0000, 32'h0000_0041, 0, 0, 64'h0E, 24);
    for (int i = 1; i <= 3; i++) checkOutput("t3_blocked_wr", {31'd0, wLog[i]}, 0);
    checkOutput("t3_wr", {31'd0, wLog[4]}, 1);
    checkOutput("t3_addr", aLog[4], 32'h0003_0000);
    checkOutput("t3_dout", {24'd0, dLog[4]}, 32'h41);
    checkOutput("t3_flag_cyc", lsbFlagCyc, 5);
    checkWrites("t3", 32'h0003_0000, 1, 32'h41);
    modelStore(32'h0003_0000, 1, 32'h41);

    // Last grant was the LSB, so a tie goes to the fetcher.
    applyStimulus(1, 1, 0, 2'd1, 32'h100, 32'h1002, 0, 0, 0, 0, 24);
    checkOutput("t4_if_cyc", ifFlagCyc, 6);
    checkOutput("t4_lsb_cyc", lsbFlagCyc, 11);
    checkOutput("t4_if_data", ifData, 32'h0000_0513);
    checkOutput("t4_lsb_data", lsbData, 32'h0000_1234);

    applyStimulus(1, 0, 0, 2'd0, 32'h100, 0, 0, 0, 0, 0, 24);
    applyStimulus(1, 1, 0, 2'd1, 32'h100, 32'h1002, 0, 0, 0, 0, 24);
    checkOutput("t4b_lsb_cyc", lsbFlagCyc, 4);
    checkOutput("t4b_if_cyc", ifFlagCyc, 11);

    applyStimulus(1, 0, 0, 2'd0, 32'h100, 0, 0, 0, 64'h10, 0, 24);
    checkOutput("t5_if_flags", ifFlagCount, 0);
    checkOutput("t5_idle_mem_a", aLog[5], 0);
    checkOutput("t5_idle_mem_wr", {31'd0, wLog[5]}, 0);

    applyStimulus(0, 1, 1, 2'd3, 0, 32'h2000, 32'hDEAD_BEEF, 0, 64'h04, 0, 24);
    checkOutput("t5b_flag_cyc", lsbFlagCyc, 5);
    checkWrites("t5b", 32'h2000, 4, 32'hDEAD_BEEF);
    modelStore(32'h2000, 4, 32'hDEAD_BEEF);
    applyStimulus(0, 1, 0, 2'd3, 0, 32'h2000, 0, 0, 0, 0, 24);
    checkOutput("t5b_readback", lsbData, 32'hDEAD_BEEF);

    // Pause in cycles 3-4: the byte issued in cycle 2 is re-addressed in cycle 5.
    applyStimulus(1, 0, 0, 2'd0, 32'h100, 0, 0, 64'h18, 0, 0, 24);
    checkOutput("t6_reissue_a", aLog[5], 32'h101);
    checkOutput("t6_flag_cyc", ifFlagCyc, 9);
    checkOutput("t6_inst", ifData, 32'h0000_0513);

    // Reset in the middle of a fetch.
    IF_addr = 32'h100; IF_req = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_mid_mem_a", mem_a, 0);
    checkOutput("rst_mid_flag", {31'd0, IF_flag}, 0);
    @(posedge clk); #1;
    rst = 1'b0; IF_req = 1'b0;
    nFlags = 0;
    repeat (8) begin
      @(negedge clk);
      if (IF_flag) nFlags++;
    end
    checkOutput("rst_mid_no_flag", nFlags, 0);
    @(posedge clk); #1;

    for (int t = 0; t < 150; t++) begin
      int kind, n, sel;
      bit perturb;
      logic [1:0]  len;
      logic [31:0] a, wd, expData;
      logic [63:0] rm, fm;
      kind = $urandom_range(0, 2);
      len = 2'($urandom_range(0, 2));
      if (len == 2'd2) len = 2'd3;
      n = (kind == 0) ? 4 : int'(len) + 1;
      a = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
      else if (sel == 1) a[17:16] = 2'b11;
      wd = $urandom;
      perturb = 1'($urandom_range(0, 1));
      rm = '0; fm = '0;
      if (perturb) begin
        for (int c = 1; c <= 10; c++) begin
          if ($urandom_range(0, 5) == 0) rm[c] = 1'b1;
          if ($urandom_range(0, 2) == 0) fm[c] = 1'b1;
        end
      end
      expData = modelLoad(a, n);
      if (kind == 0) begin
        applyStimulus(1, 0, 0, 2'd0, a, 0, 0, rm, 0, fm, 24);
        checkOutput("rnd_if_count", ifFlagCount, 1);
        checkOutput("rnd_if_data", ifData, expData);
        if (!perturb) checkOutput("rnd_if_cyc", ifFlagCyc, n + 2);
      end else if (kind == 1) begin
        applyStimulus(0, 1, 0, len, 0, a, 0, rm, 0, fm, 24);
        checkOutput("rnd_ld_count", lsbFlagCount, 1);
        checkOutput("rnd_ld_data", lsbData, expData);
        if (!perturb) checkOutput("rnd_ld_cyc", lsbFlagCyc, n + 2);
      end else begin
        applyStimulus(0, 1, 1, len, 0, a, wd, rm, 0, fm, 24);
        checkOutput("rnd_st_count", lsbFlagCount, 1);
        checkWrites("rnd_st", a, n, wd);
        if (!perturb) checkOutput("rnd_st_cyc", lsbFlagCyc, n + 1);
        modelStore(a, n, wd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
